uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the counterpart of the board-level tx transmitter. It deserializes an asynchronous 8N1 or 8-odd-parity-1 frame from the Sin pin. It presents the byte on Dout with a one-cycle Receive strobe and reports parity and framing errors. Top level drives a seven-segment display and LEDs from Dout.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock in Hz.
BAUD_RATE, 19_200, line bit rate.
PARITY_EN, 1, 1 = odd parity bit expected after data; 0 = no parity bit.
Derived: BAUD_COUNT = CLK_FREQUENCY/BAUD_RATE (integer divide, 5208); HALF_COUNT = BAUD_COUNT/2 (2604).

Ports:
clk  input  1  system clock, all logic on rising edge.
Reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
Sin  input  1  asynchronous serial line, idle high.
Dout  output  8  last received byte.
Receive  output  1  one-cycle strobe: new byte on Dout.
parity_error  output  1  parity result of last frame.
frame_error  output  1  stop-bit result of last frame.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (Reset=0, asynchronous):
  - Dout=0, Receive=0, parity_error=0, frame_error=0, busy=0.
  - State=IDLE, counters=0.
  - Both synchronizer flops=1 (idle line).
  - Asserting Reset mid-frame aborts the frame; no Receive is issued.
- Input: 2-flop synchronizer on Sin; rx_s is the second-flop output. A third flop rx_prev is used for edge detect. Nothing samples raw Sin.
- Single baud counter, width clog2(BAUD_COUNT); cleared on every state entry. Bit counter, 3 bits.
- States:
  - IDLE: busy=0. When rx_prev=1 and rx_s=0 (falling edge), go to START. A line held low never re-triggers.
  - START: when counter==HALF_COUNT-1, sample rx_s.
    - 0: go to DATA, bit counter=0.
    - 1: glitch; go to IDLE with no outputs changed.
  - DATA: when counter==BAUD_COUNT-1, sample rx_s.
    - Shift right into shift register, MSB insert, so bits arrive LSB first.
    - After the 8th bit (bit counter==7), go to PARITY if PARITY_EN else STOP.
  - PARITY: when counter==BAUD_COUNT-1, capture parity bit p; go to STOP.
  - STOP: when counter==BAUD_COUNT-1, sample rx_s. In that same cycle update, all registered, visible next cycle:
    - Dout <= shift register.
    - frame_error <= ~rx_s.
    - parity_error <= PARITY_EN ? ~(^{shreg,p}) : 0 (odd parity: total ones including p must be odd).
    - Receive <= 1 for exactly one cycle.
    - Go to IDLE.
- Sampling timing:
  - Start bit is sampled at its centre; all later bits at their centres, spaced BAUD_COUNT cycles apart.
  - IDLE is re-entered at the stop-bit centre, so a start bit immediately after the stop bit is caught (back-to-back frames).
- Flag and data retention:
  - busy=1 in START/DATA/PARITY/STOP.
  - Dout, parity_error and frame_error hold until the next completed frame.
  - Frames with errors still update Dout and pulse Receive.
- Latency: Receive rises 2 + HALF_COUNT + (8+PARITY_EN+1)*BAUD_COUNT + 2 cycles (±1) after the Sin falling edge at the pin.
- Tolerance: baud mismatch up to ±2% must decode correctly, because mid-bit sampling is used.
- No flow control: unread bytes are overwritten.

Test Plan:
1. Hold Reset=0 with Sin toggling, then release.
   -> All outputs 0 and busy=0; first Receive only after a full valid frame.
2. PARITY_EN=1; send 0x55 with parity 1, stop 1.
   -> One Receive pulse; Dout=0x55; parity_error=0; frame_error=0.
   -> Pulse arrives at the latency formula ±1 cycle.
3. Send 0x07 with parity 1 (wrong; correct is 0).
   -> Dout=0x07, parity_error=1.
   -> Next frame 0xA3 with parity 1 -> parity_error clears to 0.
4. Send 0xA3 with stop bit 0, then line held low for 3 bit times, then high, then 0x3C.
   -> First frame: frame_error=1, Dout=0xA3; no extra Receive while the line is low.
   -> Second frame: Dout=0x3C, frame_error=0.
5. 0-pulse on Sin of HALF_COUNT/2 cycles.
   -> Return to IDLE; no Receive; Dout unchanged.
   -> Then frames 0x01, 0x80 and 0xFF sent back-to-back with no idle gap -> three Receive pulses with the correct bytes.
6. Assert Reset during DATA bit 4 of a 0xF0 frame, deassert, then send 0x12.
   -> No Receive for 0xF0; Dout=0x00 until 0x12 is received, then Dout=0x12.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver for 8N1 or 8-odd-parity-1 frames.
// Samples each bit at its centre, presents the byte on Dout with a one-cycle
// Receive strobe, and flags parity and stop-bit errors of the last frame.
module uart_rx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int PARITY_EN     = 1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sin,
    output logic [7:0] Dout,
    output logic       Receive,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int BAUD_COUNT = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam int CW         = $clog2(BAUD_COUNT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_COUNT - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line synchronizer and edge-detect history
    logic          rx_meta_reg;
    logic          rx_s_reg;
    logic          rx_prev_reg;

    state_t        state_reg,   state_next;
    logic [CW-1:0] cnt_reg,     cnt_next;
    logic [2:0]    bit_reg,     bit_next;
    logic [7:0]    shreg_reg,   shreg_next;
    logic          par_reg,     par_next;
    logic [7:0]    dout_reg,    dout_next;
    logic          receive_reg, receive_next;
    logic          perr_reg,    perr_next;
    logic          ferr_reg,    ferr_next;

    // Two-flop synchronizer plus one history flop; idle line resets to 1
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= Sin;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    // State, counters, shift register and output registers
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shreg_reg   <= '0;
            par_reg     <= 1'b0;
            dout_reg    <= '0;
            receive_reg <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shreg_reg   <= shreg_next;
            par_reg     <= par_next;
            dout_reg    <= dout_next;
            receive_reg <= receive_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
        end
    end

    // Next-state logic: counter restarts on every state entry and per data bit
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CW'(1);
        bit_next     = bit_reg;
        shreg_next   = shreg_reg;
        par_next     = par_reg;
        dout_next    = dout_reg;
        receive_next = 1'b0;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // A line that stays low after a bad stop bit has no edge here
                if (rx_prev_reg && !rx_s_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s_reg) begin
                        state_next = DATA;
                        bit_next   = '0;
                    end else begin
                        // Start bit gone by its centre: treat as a glitch
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_reg == BAUD_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s_reg, shreg_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_reg == BAUD_LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_s_reg;
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at the stop-bit centre so a following start edge is seen
                if (cnt_reg == BAUD_LAST) begin
                    cnt_next     = '0;
                    dout_next    = shreg_reg;
                    ferr_next    = ~rx_s_reg;
                    perr_next    = (PARITY_EN != 0) ? ~(^{shreg_reg, par_reg}) : 1'b0;
                    receive_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign Dout         = dout_reg;
    assign Receive      = receive_reg;
    assign parity_error = perr_reg;
    assign frame_error  = ferr_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, hand-written corner sequences and
// randomized frames (with baud skew) checked against a frame-level model.
module tb_uart_rx;

    localparam int CLK_HZ  = 2_000_000;
    localparam int BAUD    = 100_000;
    localparam int B       = CLK_HZ / BAUD;   // 20 cycles per bit
    localparam int H       = B / 2;           // 10
    localparam int BIT_NS  = B * 10;          // 10 ns clock period
    localparam int EXP_LAT = 2 + H + (8 + 1 + 1) * B + 2;

    logic       clk;
    logic       Reset;
    logic       Sin;
    logic [7:0] Dout;
    logic       Receive;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    uart_rx #(
        .CLK_FREQUENCY(CLK_HZ),
        .BAUD_RATE    (BAUD),
        .PARITY_EN    (1)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Sin         (Sin),
        .Dout        (Dout),
        .Receive     (Receive),
        .parity_error(parity_error),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dout;
        logic       perr;
        logic       ferr;
        int         at;
    } rx_t;

    rx_t rx_q[$];

    // Collect every Receive strobe, sampled away from the active edge
    always @(negedge clk) begin
        if (Receive) rx_q.push_back('{Dout, parity_error, frame_error, cyc});
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    int checks   = 0;
    int failures = 0;
    int fall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int bit_ns);
        Sin = 1'b0;
        fall_cyc = cyc;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            Sin = d[i];
            #(bit_ns);
        end
        Sin = p;
        #(bit_ns);
        Sin = stop;
        #(bit_ns);
    endtask

    // Wait (bounded) until at least n strobes have been collected
    task automatic wait_rx(input int n, input string name);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 4 * B) begin
            @(negedge clk);
            t++;
        end
        if (rx_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: strobes=%0d required=%0d", name, rx_q.size(), n);
        end
    endtask

    task automatic expect_rx(input string name, input logic [7:0] d, input logic pe, input logic fe);
        rx_t r;
        wait_rx(1, name);
        if (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            check({name, " dout"}, 32'(r.dout), 32'(d));
            check({name, " perr"}, 32'(r.perr), 32'(pe));
            check({name, " ferr"}, 32'(r.ferr), 32'(fe));
        end
    endtask

    initial begin
        rx_t        r;
        logic [7:0] d;
        logic       p;
        logic       st;
        logic       pe;
        logic [7:0] last;
        int         lat;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        // Reset held with a noisy line
        Reset = 1'b0;
        Sin   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            Sin = 1'($urandom);
        end
        check("reset Dout", 32'(Dout), 32'h0);
        check("reset Receive", 32'(Receive), 32'h0);
        check("reset perr", 32'(parity_error), 32'h0);
        check("reset ferr", 32'(frame_error), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        Sin = 1'b1;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("post-reset no strobe", 32'(rx_q.size()), 32'h0);
        check("post-reset busy", 32'(busy), 32'h0);

        // Directed vector table, one frame at a time
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, BIT_NS);
            wait_rx(1, "vec");
            if (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                check($sformatf("vec%0d dout", i), 32'(r.dout), 32'(vecs[i].exp_dout));
                check($sformatf("vec%0d perr", i), 32'(r.perr), 32'(vecs[i].exp_perr));
                check($sformatf("vec%0d ferr", i), 32'(r.ferr), 32'(vecs[i].exp_ferr));
                if (i == 0) begin
                    lat = r.at - fall_cyc;
                    checks++;
                    if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
                        failures++;
                        $display("FAIL latency: actual=%0d required=%0d+-1", lat, EXP_LAT);
                    end
                end
            end
            check($sformatf("vec%0d single strobe", i), 32'(rx_q.size()), 32'h0);
            #(BIT_NS);
        end

        // Bad stop bit, then line held low for three bit times
        @(negedge clk);
        send_frame(8'hA3, 1'b1, 1'b0, BIT_NS);
        #(3 * BIT_NS);
        check("low line strobes", 32'(rx_q.size()), 32'h1);
        check("low line busy", 32'(busy), 32'h0);
        if (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            check("ferr frame dout", 32'(r.dout), 32'hA3);
            check("ferr frame ferr", 32'(r.ferr), 32'h1);
        end
        Sin = 1'b1;
        #(BIT_NS);
        send_frame(8'h3C, 1'b1, 1'b1, BIT_NS);
        expect_rx("after ferr 3C", 8'h3C, 1'b0, 1'b0);
        #(BIT_NS);

        // Short glitch must not produce a frame
        last = Dout;
        @(negedge clk);
        Sin = 1'b0;
        repeat (H / 2) @(negedge clk);
        Sin = 1'b1;
        repeat (3 * B) @(negedge clk);
        check("glitch no strobe", 32'(rx_q.size()), 32'h0);
        check("glitch busy", 32'(busy), 32'h0);
        check("glitch Dout held", 32'(Dout), 32'(last));

        // Back-to-back frames with no idle gap
        for (int i = 4; i < 7; i++) send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, BIT_NS);
        wait_rx(3, "b2b");
        for (int i = 4; i < 7; i++) begin
            if (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                check($sformatf("b2b%0d dout", i), 32'(r.dout), 32'(vecs[i].exp_dout));
                check($sformatf("b2b%0d perr", i), 32'(r.perr), 32'(vecs[i].exp_perr));
            end
        end
        #(BIT_NS);

        // Reset in the middle of data bit 4 of 0xF0
        @(negedge clk);
        fork
            send_frame(8'hF0, 1'b1, 1'b1, BIT_NS);
            begin
                #(BIT_NS + 4 * BIT_NS + BIT_NS / 2);
                Reset = 1'b0;
                #30;
                Reset = 1'b1;
            end
        join
        repeat (2 * B) @(negedge clk);
        check("abort no strobe", 32'(rx_q.size()), 32'h0);
        check("abort Dout", 32'(Dout), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        send_frame(8'h12, 1'b1, 1'b1, BIT_NS);
        expect_rx("after abort 12", 8'h12, 1'b0, 1'b0);

        // Randomized frames with up to 2% baud skew against a frame model
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            p  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) p = ~p;
            st = ($urandom_range(0, 4) != 0);
            pe = (($countones(d) + int'(p)) % 2 == 0);
            #($urandom_range(1, 300));
            send_frame(d, p, st, $urandom_range(BIT_NS - BIT_NS / 50, BIT_NS + BIT_NS / 50));
            expect_rx($sformatf("rnd%0d", n), d, pe, ~st);
            Sin = 1'b1;
            #(BIT_NS);
            check($sformatf("rnd%0d single strobe", n), 32'(rx_q.size()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
